// File: rtl/psdifir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psdifir_pkg
// Description : Shared constants, FSM state type and slot-bit helper for the
//               audio output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package psdifir_pkg;

  localparam int SAMPLE_W      = 18;
  localparam int CLKDIV_DEF    = 16;
  localparam int SLOT_BITS_DEF = 24;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit carried at position pos of a slot: sample MSB first, zero padding
  // once the sample bits are exhausted.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s,
                                    input logic [4:0]          pos);
    logic [4:0] idx;
    slot_bit = 1'b0;
    if (pos < 5'(SAMPLE_W)) begin
      idx      = 5'(SAMPLE_W - 1) - pos;
      slot_bit = s[idx];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_out_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_serializer_if
// Description : Sample-input strobe/bus and DAC-side serial/status signals of
//               the audio output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_out_serializer_if;
  import psdifir_pkg::*;

  logic                datain_ready;
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                sclk;
  logic                lrclk;
  logic                sdata;
  logic                busy;
  logic                overrun;
  logic                underrun;

  // Sample producer (FIR output stage) side.
  modport master (
    output datain_ready, left_in, right_in,
    input  sclk, lrclk, sdata, busy, overrun, underrun
  );

  // Serializer side.
  modport slave (
    input  datain_ready, left_in, right_in,
    output sclk, lrclk, sdata, busy, overrun, underrun
  );

endinterface
`default_nettype wire

// File: rtl/sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : sclk_gen
// Description : Divides the master clock down to the serial bit clock and
//               flags the cycle in which sclk is about to rise or fall.
// Revision    : 1.0 - initial release
// ============================================================================
module sclk_gen
  import psdifir_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  wire  clk_i,
  input  wire  rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             sclk_q;
  logic             w_wrap;

  // Strobes are asserted in the cycle whose closing edge toggles sclk, so a
  // consumer registering on the same edge changes together with sclk.
  assign w_wrap = en_i && (div_q == DIV_W'(CLKDIV - 1));
  assign rise_o = w_wrap && !sclk_q;
  assign fall_o = w_wrap && sclk_q;
  assign sclk_o = sclk_q;

  // Half-period divider; held at zero with sclk low while disabled or cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (clr_i || !en_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (w_wrap) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_serializer
// Description : Buffers one stereo sample pair and shifts it out to a DAC as
//               left-justified, MSB-first slots framed by lrclk.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_out_serializer
  import psdifir_pkg::*;
#(
  parameter int CLKDIV    = CLKDIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  wire                    clockext100MHz,
  input  wire                    reset,
  audio_out_serializer_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(2 * SLOT_BITS - 1);

  state_e              state_q;
  logic                valid_q;
  logic [SAMPLE_W-1:0] pend_l_q, pend_r_q;
  logic [SAMPLE_W-1:0] frame_l_q, frame_r_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, sdata_q, busy_q, overrun_q, underrun_q;

  logic                w_sclk, w_fall, w_rise_unused;
  logic                w_last, w_load, w_slot_d, w_bit_d;
  logic [4:0]          w_pos_d;

  sclk_gen #(
    .CLKDIV (CLKDIV)
  ) u_sclk_gen (
    .clk_i  (clockext100MHz),
    .rst_i  (reset),
    .en_i   (state_q == RUN),
    .clr_i  (w_load),
    .sclk_o (w_sclk),
    .rise_o (w_rise_unused),
    .fall_o (w_fall)
  );

  // A frame load happens either straight out of IDLE or on the falling edge
  // that closes the last bit of a frame, provided a pair is pending.
  assign w_last   = (bit_cnt_q == LAST_BIT);
  assign w_load   = valid_q && ((state_q == IDLE) || (w_fall && w_last));

  // Slot and bit value for the bit that starts at the next sclk fall.
  assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
  assign w_slot_d  = (bit_cnt_d >= CNT_W'(SLOT_BITS));
  assign w_pos_d   = w_slot_d ? 5'(bit_cnt_d - CNT_W'(SLOT_BITS)) : 5'(bit_cnt_d);
  assign w_bit_d   = slot_bit(w_slot_d ? frame_r_q : frame_l_q, w_pos_d);

  // Pending pair: a strobe coinciding with a load refills the buffer cleanly;
  // a strobe onto a still-unconsumed pair overwrites it and flags overrun.
  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pend_l_q  <= '0;
      pend_r_q  <= '0;
      overrun_q <= 1'b0;
    end else if (bus.datain_ready) begin
      pend_l_q <= bus.left_in;
      pend_r_q <= bus.right_in;
      valid_q  <= 1'b1;
      if (valid_q && !w_load) begin
        overrun_q <= 1'b1;
      end
    end else if (w_load) begin
      valid_q <= 1'b0;
    end
  end

  // Frame FSM with registered serial outputs; RUN only leaves via reset.
  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      bit_cnt_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_load) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            frame_l_q <= pend_l_q;
            frame_r_q <= pend_r_q;
            bit_cnt_q <= '0;
            lrclk_q   <= 1'b0;
            sdata_q   <= pend_l_q[SAMPLE_W-1];
          end
        end
        RUN: begin
          if (w_fall) begin
            if (w_last) begin
              bit_cnt_q <= '0;
              lrclk_q   <= 1'b0;
              if (valid_q) begin
                frame_l_q <= pend_l_q;
                frame_r_q <= pend_r_q;
                sdata_q   <= pend_l_q[SAMPLE_W-1];
              end else begin
                // Nothing to send: emit a silent frame instead.
                frame_l_q  <= '0;
                frame_r_q  <= '0;
                sdata_q    <= 1'b0;
                underrun_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_d;
              lrclk_q   <= w_slot_d;
              sdata_q   <= w_bit_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sclk     = w_sclk;
  assign bus.lrclk    = lrclk_q;
  assign bus.sdata    = sdata_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_out_serializer
// Description : Scoreboard bench for audio_out_serializer: expected
//               {lrclk,sdata} bits are queued with each stimulus and compared
//               at every sclk rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_out_serializer;
  import psdifir_pkg::*;

  localparam int CLKDIV    = 2;
  localparam int SLOT_BITS = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  audio_out_serializer_if bus();

  audio_out_serializer #(
    .CLKDIV    (CLKDIV),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .clockext100MHz (clk),
    .reset          (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       sclk_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {lrclk,sdata} sequence of one frame.
  task automatic push_frame(input logic [17:0] l, input logic [17:0] r);
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < SLOT_BITS; b++) begin
        logic [17:0] smp;
        logic        bv;
        smp = (s == 0) ? l : r;
        bv  = (b < 18) ? smp[5'(17 - b)] : 1'b0;
        exp_q.push_back({1'(s), bv});
      end
    end
  endtask

  // Called just after a posedge; holds the strobe for exactly one cycle.
  task automatic strobe(input logic [17:0] l, input logic [17:0] r);
    bus.datain_ready = 1'b1;
    bus.left_in      = l;
    bus.right_in     = r;
    @(posedge clk);
    #1;
    bus.datain_ready = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.datain_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: one expected bit per sclk rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sclk_prev <= 1'b0;
    end else begin
      if (bus.sclk && !sclk_prev && exp_q.size() > 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("frame_bit", 32'({bus.lrclk, bus.sdata}), 32'(e));
      end
      sclk_prev <= bus.sclk;
    end
  end

  logic [17:0] a_l, a_r, b_l, b_r, c_l, c_r;

  initial begin
    bus.datain_ready = 1'b0;
    bus.left_in      = '0;
    bus.right_in     = '0;
    rst              = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk",     32'(bus.sclk),     32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_overrun",  32'(bus.overrun),  32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, latency, then an underrun frame of zeros.
    push_frame(18'h2AAAA, 18'h15555);
    push_frame(18'h0, 18'h0);
    strobe(18'h2AAAA, 18'h15555);
    @(negedge clk);
    chk("busy_T1", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("busy_T2",     32'(bus.busy),     32'd1);
    chk("sdata_T2",    32'(bus.sdata),    32'd1);
    chk("sclk_T2",     32'(bus.sclk),     32'd0);
    chk("underrun_T2", 32'(bus.underrun), 32'd0);
    @(negedge clk);
    chk("sclk_T3", 32'(bus.sclk), 32'd0);
    @(negedge clk);
    chk("sclk_T4", 32'(bus.sclk), 32'd1);
    @(posedge clk);
    #1;
    wait_drain(1000);
    chk("underrun_set", 32'(bus.underrun), 32'd1);
    chk("busy_stays",   32'(bus.busy),     32'd1);
    chk("no_overrun",   32'(bus.overrun),  32'd0);
    do_reset();
    chk("rst2_busy",     32'(bus.busy),     32'd0);
    chk("rst2_underrun", 32'(bus.underrun), 32'd0);

    // Overrun: second pair overwritten by a third 3 cycles later.
    a_l = 18'($urandom); a_r = 18'($urandom);
    b_l = 18'($urandom); b_r = 18'($urandom);
    c_l = 18'($urandom); c_r = 18'($urandom);
    push_frame(a_l, a_r);
    strobe(a_l, a_r);
    repeat (40) @(posedge clk);
    #1;
    strobe(b_l, b_r);
    @(negedge clk);
    chk("ovr_before", 32'(bus.overrun), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    push_frame(c_l, c_r);
    strobe(c_l, c_r);
    @(negedge clk);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    @(posedge clk);
    #1;
    wait_drain(1000);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    do_reset();

    // Strobe exactly in the frame-load cycle while a pair is pending.
    a_l = 18'($urandom); a_r = 18'($urandom);
    b_l = 18'($urandom); b_r = 18'($urandom);
    c_l = 18'($urandom); c_r = 18'($urandom);
    push_frame(a_l, a_r);
    strobe(a_l, a_r);
    repeat (10) @(posedge clk);
    #1;
    push_frame(b_l, b_r);
    strobe(b_l, b_r);
    repeat (181) @(posedge clk);
    #1;
    push_frame(c_l, c_r);
    strobe(c_l, c_r);
    @(negedge clk);
    chk("sim_no_ovr", 32'(bus.overrun), 32'd0);
    @(posedge clk);
    #1;
    wait_drain(2000);
    chk("sim_no_ovr_end", 32'(bus.overrun), 32'd0);
    do_reset();

    // Reset during bit 30 (right slot), then a fresh frame.
    a_l = 18'($urandom);
    a_r = 18'($urandom) | 18'h00800;
    push_frame(a_l, a_r);
    strobe(a_l, a_r);
    repeat (122) @(posedge clk);
    #1;
    chk("pre_rst_bits",  32'(exp_q.size()), 32'd18);
    chk("pre_rst_busy",  32'(bus.busy),     32'd1);
    chk("pre_rst_lrclk", 32'(bus.lrclk),    32'd1);
    chk("pre_rst_sdata", 32'(bus.sdata),    32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sclk",     32'(bus.sclk),     32'd0);
    chk("mid_rst_lrclk",    32'(bus.lrclk),    32'd0);
    chk("mid_rst_sdata",    32'(bus.sdata),    32'd0);
    chk("mid_rst_busy",     32'(bus.busy),     32'd0);
    chk("mid_rst_overrun",  32'(bus.overrun),  32'd0);
    chk("mid_rst_underrun", 32'(bus.underrun), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    b_l = 18'($urandom) | 18'h20000;
    b_r = 18'($urandom);
    push_frame(b_l, b_r);
    strobe(b_l, b_r);
    @(negedge clk);
    @(negedge clk);
    chk("restart_sdata", 32'(bus.sdata), 32'd1);
    chk("restart_lrclk", 32'(bus.lrclk), 32'd0);
    chk("restart_busy",  32'(bus.busy),  32'd1);
    @(posedge clk);
    #1;
    wait_drain(1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
